// File: rtl/f3m_frob_iter.sv
// f3m_frob_iter
//   Iterated Frobenius map over GF(3^M), polynomial basis, trinomial modulus
//   f(x) = x^M + x^K + 2. Computes c = a^(3^n) using one cubing per clock.
//
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   start    request pulse, sampled only while idle
//   a        operand, trit i at bits [2i+1:2i] (00=0, 01=1, 10=2, 11 read as 0)
//   n        number of cubings to apply (no reduction modulo M)
//   busy     high from acceptance until the result is written
//   done     one-cycle pulse when c becomes valid
//   c        result, held until the next completed job
module f3m_frob_iter #(
  parameter int unsigned M  = 97,
  parameter int unsigned K  = 12,
  parameter int unsigned NW = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2*M-1:0]   a,
  input  logic [NW-1:0]    n,
  output logic             busy,
  output logic             done,
  output logic [2*M-1:0]   c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2*M-1:0]  r_q, r_d;
  logic [2*M-1:0]  c_q, c_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [2*M-1:0]  a_norm;
  logic [2*M-1:0]  r_cube;

  // Trit addition mod 3 on the 2-bit encoding (operands are always legal).
  function automatic logic [1:0] tadd(input logic [1:0] x, input logic [1:0] y);
    logic [2:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= 3'd3) begin
      s = s - 3'd3;
    end
    return s[1:0];
  endfunction

  // Multiplication by 2 mod 3: swaps the encodings of 1 and 2, keeps 0.
  function automatic logic [1:0] tneg(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // Cubing is linear over GF(3) and fixes every trit, so it is a spread of
  // trit i to position 3i followed by reduction with x^M = 2x^K + 1.
  // Reducing from the top down guarantees every fold lands on a position
  // not yet visited, so one pass is sufficient.
  function automatic logic [2*M-1:0] cube(input logic [2*M-1:0] v);
    logic [1:0]     t [3*M-2];
    logic [2*M-1:0] res;
    for (int unsigned i = 0; i < 3*M-2; i++) begin
      t[i] = '0;
    end
    for (int unsigned i = 0; i < M; i++) begin
      t[3*i] = v[2*i +: 2];
    end
    for (int unsigned d = 3*M-3; d >= M; d--) begin
      t[d-M+K] = tadd(t[d-M+K], tneg(t[d]));
      t[d-M]   = tadd(t[d-M], t[d]);
      t[d]     = '0;
    end
    res = '0;
    for (int unsigned i = 0; i < M; i++) begin
      res[2*i +: 2] = t[i];
    end
    return res;
  endfunction

  // Illegal 11 trits are folded to 0 on entry so the datapath only ever
  // carries legal encodings.
  always_comb begin
    a_norm = '0;
    for (int unsigned i = 0; i < M; i++) begin
      a_norm[2*i +: 2] = (a[2*i +: 2] == 2'b11) ? 2'b00 : a[2*i +: 2];
    end
  end

  always_comb begin
    r_cube = cube(r_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. RUN leaves on the edge that performs the last cube.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (n == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (cnt_q == NW'(1)) begin
          state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic. busy/done are registered so that busy drops
  // and done rises on the same edge that writes c.
  always_comb begin
    r_d    = r_q;
    c_d    = c_q;
    cnt_d  = cnt_q;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d    = a_norm;
          cnt_d  = n;
          busy_d = 1'b1;
        end
      end
      RUN: begin
        r_d    = r_cube;
        cnt_d  = cnt_q - NW'(1);
        busy_d = 1'b1;
      end
      FIN: begin
        c_d    = r_q;
        done_d = 1'b1;
      end
      default: begin
        r_d = r_q;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_f3m_frob_iter.sv
// Testbench for f3m_frob_iter: randomized operands checked against a field
// model that cubes by genuine polynomial multiplication modulo
// x^M + x^K + 2, plus fixed directed cases.
module tb_f3m_frob_iter;

  localparam int unsigned M  = 97;
  localparam int unsigned K  = 12;
  localparam int unsigned NW = 8;
  localparam int unsigned W  = 2*M;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [W-1:0]  a;
  logic [NW-1:0] n;
  logic          busy;
  logic          done;
  logic [W-1:0]  c;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] c_prev;

  always #5 clk = ~clk;

  f3m_frob_iter #(.M(M), .K(K), .NW(NW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .n       (n),
    .busy    (busy),
    .done    (done),
    .c       (c)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] norm(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < M; i++) begin
      if (v[2*i +: 2] == 2'b11) r[2*i +: 2] = 2'b00;
    end
    return r;
  endfunction

  // Schoolbook product in GF(3)[x], then reduction modulo x^M + x^K + 2.
  function automatic logic [W-1:0] mdl_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    int p [2*M-1];
    int t;
    logic [W-1:0] r;
    for (int i = 0; i < 2*M-1; i++) p[i] = 0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < M; j++) begin
        p[i+j] += int'(x[2*i +: 2]) * int'(y[2*j +: 2]);
      end
    end
    for (int d = 2*M-2; d >= int'(M); d--) begin
      t = p[d] % 3;
      p[d-M+K] += 2*t;
      p[d-M]   += t;
      p[d]      = 0;
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(p[i] % 3);
    return r;
  endfunction

  function automatic logic [W-1:0] mdl_frob(input logic [W-1:0] av, input int cnt);
    logic [W-1:0] x;
    x = norm(av);
    for (int i = 0; i < cnt; i++) x = mdl_mul(mdl_mul(x, x), x);
    return x;
  endfunction

  function automatic logic [W-1:0] rand_elem();
    logic [W-1:0] v;
    for (int i = 0; i < M; i++) v[2*i +: 2] = 2'($urandom_range(0, 2));
    return v;
  endfunction

  function automatic logic [W-1:0] rand_raw();
    logic [W-1:0] v;
    for (int i = 0; i < M; i++) v[2*i +: 2] = 2'($urandom_range(0, 3));
    return v;
  endfunction

  function automatic logic has11(input logic [W-1:0] v);
    logic f;
    f = 1'b0;
    for (int i = 0; i < M; i++) if (v[2*i +: 2] == 2'b11) f = 1'b1;
    return f;
  endfunction

  // ---------------- job handling ----------------
  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic launch(input logic [W-1:0] av, input logic [NW-1:0] nv);
    start = 1'b1;
    a     = av;
    n     = nv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = rand_raw();
    n     = NW'($urandom);
  endtask

  // Samples at negedges; returns at the negedge where done is high.
  task automatic await_done(input string tag, input int nv, input bit mid_start,
                            output logic [W-1:0] cres);
    int s;
    int bcnt;
    s    = 0;
    bcnt = 0;
    while (!done && s < nv + 10) begin
      if (s == 0) check({tag, ":c_held"}, c, c_prev);
      if (busy) bcnt++;
      start = (mid_start && s == 2);
      @(negedge clk);
      s++;
    end
    start = 1'b0;
    check({tag, ":latency"}, W'(s), W'(nv + 1));
    check({tag, ":busy_cycles"}, W'(bcnt), W'(nv + 1));
    check({tag, ":busy_at_done"}, W'(busy), '0);
    check({tag, ":no11"}, W'(has11(c)), '0);
    cres   = c;
    c_prev = c;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] x, y, r, e;
    int nv, dcnt;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    n       = '0;
    c_prev  = '0;
    repeat (2) @(negedge clk);
    check("rst:busy", W'(busy), '0);
    check("rst:done", W'(done), '0);
    check("rst:c", c, '0);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: constant 2 is fixed by any number of cubings
    launch(W'(2), 0);
    await_done("t1_n0", 0, 1'b0, r);
    check("t1_n0:c", r, W'(2));
    @(negedge clk);
    check("t1:done_pulse", W'(done), '0);
    launch(W'(2), 5);
    await_done("t1_n5", 5, 1'b0, r);
    check("t1_n5:c", r, W'(2));

    // 2: x^33 cubed is x^99 = 2x^14 + x^2
    x = '0;
    x[66 +: 2] = 2'b01;
    e = '0;
    e[28 +: 2] = 2'b10;
    e[4 +: 2]  = 2'b01;
    launch(x, 1);
    await_done("t2", 1, 1'b0, r);
    check("t2:c", r, e);
    check("t2:model", r, mdl_frob(x, 1));

    // 3: a^(3^M) = a, also for 2M
    x = rand_elem();
    launch(x, NW'(M));
    await_done("t3_M", M, 1'b0, r);
    check("t3_M:c", r, x);
    launch(x, NW'(2*M));
    await_done("t3_2M", 2*M, 1'b0, r);
    check("t3_2M:c", r, x);

    // 4: n=3 with a stray start mid-run, then back-to-back n=2
    x = rand_elem();
    launch(x, 3);
    await_done("t4a", 3, 1'b1, r);
    check("t4a:c", r, mdl_frob(x, 3));
    y = rand_elem();
    launch(y, 2);
    await_done("t4b", 2, 1'b0, r);
    check("t4b:c", r, mdl_frob(y, 2));

    for (int k = 0; k < 6; k++) begin
      x  = rand_elem();
      nv = $urandom_range(0, 12);
      launch(x, NW'(nv));
      await_done($sformatf("t4r%0d", k), nv, (nv >= 3), r);
      check($sformatf("t4r%0d:c", k), r, mdl_frob(x, nv));
    end

    // 5: illegal 11 trits read as zero
    x = rand_raw();
    x[1:0]           = 2'b11;
    x[2*(M-1) +: 2]  = 2'b11;
    launch(x, 0);
    await_done("t5_n0", 0, 1'b0, r);
    check("t5_n0:c", r, norm(x));
    launch(x, 4);
    await_done("t5_n4", 4, 1'b0, r);
    check("t5_n4:c", r, mdl_frob(x, 4));

    // 6: asynchronous reset during RUN aborts the job
    x = rand_elem();
    launch(x, 50);
    repeat (10) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6:busy", W'(busy), '0);
    check("t6:done", W'(done), '0);
    check("t6:c", c, '0);
    c_prev = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("t6:no_done", W'(dcnt), '0);
    y = rand_elem();
    launch(y, 7);
    await_done("t6_after", 7, 1'b0, r);
    check("t6_after:c", r, mdl_frob(y, 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
